vector_mem_sequencer: RTL
=========================

VECTOR_MEM_SEQUENCER -- requirements
Module: vector_mem_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 4, number of vector elements per access.
REQ-002 SHALL have parameter DW, default 8, element width in bits.
REQ-003 SHALL have parameter AW, default 32, memory address width in bits.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 EnableRead  input  1  vector-load request from control unit.
REQ-007 EnableWrite  input  1  vector-store request from control unit.
REQ-008 base_addr  input  AW  element-0 address; sampled at request acceptance.
REQ-009 wdata_vec  input  LANES*DW  store data; lane i at bits [i*DW +: DW]; sampled at acceptance.
REQ-010 mem_rdata  input  DW  data memory read data; valid the cycle after mem_re.
REQ-011 mem_addr  output  AW  element address to data memory.
REQ-012 mem_wdata  output  DW  element store data.
REQ-013 mem_re  output  1  element read strobe.
REQ-014 mem_we  output  1  element write strobe.
REQ-015 rdata_vec  output  LANES*DW  assembled load result, same lane packing as wdata_vec.
REQ-016 vec_valid  output  1  one-cycle pulse; rdata_vec holds the complete load.
REQ-017 stall  output  1  pipeline freeze request while a vector access is in flight.

Function
REQ-018 SHALL implement states IDLE, READ, RLAST, RDONE, WRITE, WDONE.
REQ-019 In IDLE, a request SHALL be accepted at a rising edge with EnableRead or EnableWrite high; EnableRead wins if both are high.
REQ-020 On acceptance, the block SHALL register base_addr, wdata_vec (write only) and clear lane index idx to 0.
REQ-021 READ: mem_re=1, mem_addr=base+idx, idx increments each cycle; after issuing lane LANES-1, the next state SHALL be RLAST.
REQ-022 At the end of READ cycle k>0 and of RLAST, mem_rdata SHALL be written to rdata_vec lane k-1 (RLAST: lane LANES-1); other lanes unchanged.
REQ-023 RDONE SHALL last one cycle with vec_valid=1, stall=0, then go to IDLE.
REQ-024 Load latency: acceptance edge to vec_valid cycle SHALL be LANES+2 cycles (READ x LANES, RLAST x1, RDONE).
REQ-025 WRITE: mem_we=1, mem_addr=base+idx, mem_wdata=registered lane idx, idx increments; after lane LANES-1, next state SHALL be WDONE.
REQ-026 WDONE SHALL last one cycle with stall=0, mem_we=0, then go to IDLE.
REQ-027 stall SHALL be 1 exactly in READ, RLAST and WRITE; combinationally derived from state, no extra cycle.
REQ-028 mem_re SHALL be 1 only in READ; mem_we only in WRITE; never both.
REQ-029 Address arithmetic SHALL be modulo 2^AW (base 0xFFFF_FFFE, LANES=4 gives FFFF_FFFE, FFFF_FFFF, 0, 1).
REQ-030 Requests SHALL be ignored outside IDLE, including in RDONE/WDONE; no queuing.
REQ-031 In non-READ/WRITE states mem_addr and mem_wdata SHALL be 0.
REQ-032 rdata_vec SHALL hold its value from RDONE until the next accepted load.

Reset
REQ-033 rst low SHALL immediately force IDLE, idx=0, rdata_vec=0, and all outputs 0, regardless of state.
REQ-034 Reset mid-access SHALL abandon the access; no further mem_re/mem_we, no vec_valid, until a new request after rst goes high.
REQ-035 The first edge after rst deasserts SHALL accept a request held high then.

Verification (LANES=4, DW=8, AW=32)
REQ-036 Load, base=0x10, memory[0x10..0x13]=11,22,33,44 -> mem_re 4 cycles addr 10,11,12,13; vec_valid at cycle 6; rdata_vec=0x44332211; stall high cycles 1-5.
REQ-037 Store, base=0x20, wdata_vec=0xDDCCBBAA -> mem_we 4 cycles, addr/data (20,AA)(21,BB)(22,CC)(23,DD); stall low in WDONE.
REQ-038 EnableRead and EnableWrite both high in IDLE -> load sequence only, mem_we never asserted.
REQ-039 Base=0xFFFFFFFE load -> addresses FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-040 rst low during READ lane 2 -> all outputs 0 within the same cycle, rdata_vec=0, no vec_valid; fresh load afterwards completes normally.
REQ-041 EnableRead held high through a whole load -> single sequence; re-accepted only at first IDLE edge after RDONE.

Source files
------------

// File: rtl/vector_mem_sequencer.sv
// rtl/vector_mem_sequencer.sv - splits one vector load/store into per-element memory accesses
//
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   EnableRead         vector-load request (wins over EnableWrite)
//   EnableWrite        vector-store request
//   base_addr          element-0 address, captured when a request is accepted
//   wdata_vec          store data, lane i at [i*DW +: DW], captured on store acceptance
//   mem_rdata          element read data, returned the cycle after mem_re
//   mem_addr           element address (0 outside READ/WRITE)
//   mem_wdata          element store data (0 outside WRITE)
//   mem_re, mem_we     element read / write strobes
//   rdata_vec          assembled load result, held until the next accepted load
//   vec_valid          one-cycle pulse when rdata_vec holds a complete load
//   stall              pipeline freeze while an access is in flight
module vector_mem_sequencer #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int AW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EnableRead,
  input  logic                  EnableWrite,
  input  logic [AW-1:0]         base_addr,
  input  logic [LANES*DW-1:0]   wdata_vec,
  input  logic [DW-1:0]         mem_rdata,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [LANES*DW-1:0]   rdata_vec,
  output logic                  vec_valid,
  output logic                  stall
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IW-1:0] LAST = IW'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    RLAST,
    RDONE,
    WRITE,
    WDONE
  } state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [AW-1:0]         base_q;
  logic [LANES*DW-1:0]   wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      rdata_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (EnableRead) begin
            state  <= READ;
            base_q <= base_addr;
            idx    <= '0;
          end else if (EnableWrite) begin
            state   <= WRITE;
            base_q  <= base_addr;
            wdata_q <= wdata_vec;
            idx     <= '0;
          end
        end
        READ: begin
          // Read data lags the strobe by one cycle, so this cycle's
          // mem_rdata belongs to the lane issued in the previous cycle.
          if (idx != '0) begin
            rdata_vec[(int'(idx) - 1) * DW +: DW] <= mem_rdata;
          end
          if (idx == LAST) begin
            state <= RLAST;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        RLAST: begin
          // Drain cycle: collect the data for the final lane.
          rdata_vec[(LANES - 1) * DW +: DW] <= mem_rdata;
          state <= RDONE;
        end
        RDONE: begin
          state <= IDLE;
        end
        WRITE: begin
          if (idx == LAST) begin
            state <= WDONE;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        WDONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state so they track reset
  // immediately and never lag the state by a cycle.
  assign mem_re    = (state == READ);
  assign mem_we    = (state == WRITE);
  assign vec_valid = (state == RDONE);
  assign stall     = (state == READ) || (state == RLAST) || (state == WRITE);

  // Address wraps modulo 2^AW through the natural AW-bit add.
  assign mem_addr  = (mem_re || mem_we) ? (base_q + AW'(idx)) : '0;
  assign mem_wdata = mem_we ? wdata_q[int'(idx) * DW +: DW] : '0;

endmodule
